seq_detector_param: RTL

Parametrised Mealy sequence detector for a serial bit stream. It recognises a compile-time pattern of `PAT_W` bits, presented MSB first. Overlapping or non-overlapping detection is selected by parameter, and detections are counted in a saturating counter. It is the general-purpose successor to the fixed 4-bit Mealy detector: it adds a sample-enable qualifier, the match-mode choice, a match counter and a current-state observation port for the bench.

---
 rtl/seq_detector_param.sv | 66 ++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: Mealy detector for a PAT_W-bit serial pattern (MSB first) with saturating match counter.
// Next-state table is built at elaboration from the pattern's prefix/suffix fallback.
module seq_detector_param #(
    parameter int PAT_W = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W = 8,
    parameter int STATE_W = $clog2(PAT_W)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d_in,
    input  logic clr_cnt,
    output logic d_out,
    output logic [STATE_W-1:0] states,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int NS = 2 ** STATE_W;
    function automatic logic pbit(int n);
        logic [PAT_W-1:0] t;
        t = PATTERN >> n;
        return t[0];
    endfunction
    // longest pattern prefix that is a suffix of (top k pattern bits + b), capped below PAT_W
    function automatic int nxt_f(int k, logic b);
        int lim, res, j;
        logic ok, sb;
        res = 0;
        lim = (k + 1 < PAT_W) ? k + 1 : PAT_W - 1;
        for (int l = 1; l <= lim; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                j = k + 1 - l + i;
                sb = (j < k) ? pbit(PAT_W - 1 - j) : b;
                if (sb != pbit(PAT_W - 1 - i)) ok = 1'b0;
            end
            if (ok) res = l;
        end
        if (k == PAT_W - 1 && b == PATTERN[0] && !OVERLAP) res = 0;
        return res;
    endfunction
    logic [STATE_W-1:0] nxt0 [NS];
    logic [STATE_W-1:0] nxt1 [NS];
    logic [STATE_W-1:0] nxt;
    for (genvar k = 0; k < NS; k++) begin : g_tbl
        localparam int N0 = (k < PAT_W) ? nxt_f(k, 1'b0) : 0;
        localparam int N1 = (k < PAT_W) ? nxt_f(k, 1'b1) : 0;
        assign nxt0[k] = STATE_W'(N0);
        assign nxt1[k] = STATE_W'(N1);
    end
    always_comb begin
        nxt = d_in ? nxt1[states] : nxt0[states];
        d_out = en && !reset && states == STATE_W'(PAT_W - 1) && d_in == PATTERN[0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            states <= '0;
            match_cnt <= '0;
        end else begin
            if (en) states <= nxt;
            if (clr_cnt) match_cnt <= '0;
            else if (d_out && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
        end
    end
endmodule
